tt_um_aes_serial: RTL and testbench
===================================

TT_UM_AES_SERIAL -- requirements
Module: tt_um_aes_serial

Interface
REQ-001 SHALL have parameter ROUNDS_PER_CLK, default 1, meaning AES-128 rounds computed per clock; legal values 1, 2, 5; other values SHALL fail elaboration.
REQ-002 SHALL have parameter DECRYPT_EN, default 1, meaning the inverse-cipher path is present; when 0, mode=1 SHALL be treated as encrypt.
REQ-003 SHALL have port clk  input  1  the single clock; all state on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port ena  input  1  when low, all state SHALL hold and all strobes SHALL be ignored.
REQ-006 SHALL have port ui_in  input  8  key or data byte being loaded.
REQ-007 SHALL have port uio_in  input  8  control: [0] load_key, [1] load_data, [2] start, [3] mode (0 encrypt, 1 decrypt), [4] rd_next; [7:5] SHALL be ignored.
REQ-008 SHALL have port uo_out  output  8  current result byte.
REQ-009 SHALL have port uio_out  output  8  [5] busy, [6] done, [7] mode_latched; [4:0] SHALL be 0.
REQ-010 SHALL have port uio_oe  output  8  constant 8'b1110_0000.

Function
REQ-011 Each cycle with load_key high and FSM idle SHALL shift ui_in into the 128-bit key register from the LSB end, so the first of 16 bytes ends in bits [127:120].
REQ-012 load_data SHALL behave identically for the data register; if load_key and load_data are both high, only the key SHALL load.
REQ-013 Loads SHALL also clear done; loads while busy SHALL be ignored.
REQ-014 FSM states SHALL be IDLE, KEXP, RUN and DONE; after reset it SHALL be in IDLE.
REQ-015 In IDLE or DONE, start high SHALL latch mode, raise busy and clear done on that edge; start while busy SHALL be ignored.
REQ-016 Encrypt start: the start edge SHALL load state = data ^ key and round = 1, and go to RUN.
REQ-017 Decrypt start: the FSM SHALL go to KEXP and run the forward key schedule for N = 10/ROUNDS_PER_CLK cycles, ROUNDS_PER_CLK steps per cycle, to reach round key 10.
REQ-018 On the final KEXP cycle, the block SHALL load state = data ^ rk10 and go to RUN.
REQ-019 Each RUN cycle SHALL apply ROUNDS_PER_CLK rounds, with the final round omitting MixColumns (InvMixColumns for decrypt).
REQ-020 Decrypt RUN SHALL derive the preceding round key via the inverse key-schedule step.
REQ-021 After round 10 the FSM SHALL enter DONE: busy low, done high, result register = state.
REQ-022 Latency from the start edge to done high SHALL be N cycles for encrypt and 2N cycles for decrypt.
REQ-023 Key and data registers SHALL be unchanged by an operation, so repeated starts reuse them.
REQ-024 uo_out SHALL equal result[127:120].
REQ-025 Each rd_next cycle in DONE SHALL rotate result left by 8 bits, so after 16 strobes byte 0 is presented again.
REQ-026 rd_next outside DONE SHALL be ignored.
REQ-027 Round and S-box logic SHALL be combinational per round; no other multicycle paths.

Reset
REQ-028 rst_n low SHALL asynchronously clear the key, data, state, result and round registers, the byte counters and mode_latched, and force IDLE.
REQ-029 During and after reset, uo_out=0, busy=0 and done=0, and uio_oe SHALL stay 8'b1110_0000.
REQ-030 Reset mid-operation SHALL abort it with no partial result visible.

Verification
REQ-031 Encrypt vector: load key 000102030405060708090a0b0c0d0e0f and data 00112233445566778899aabbccddeeff, start mode=0 -> done after 10 cycles (R=1); 16 reads give 69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-032 Decrypt vector: same key, data 69c4e0d86a7b0430d8cdb78070b4c55a, mode=1 -> done after 20 cycles; output 00112233445566778899aabbccddeeff.
REQ-033 Parameter sweep: ROUNDS_PER_CLK=2 and 5 -> same ciphertext, encrypt latency 5 and 2 cycles, decrypt latency 10 and 4 cycles.
REQ-034 Conflicts: start, load_key and load_data asserted mid-RUN -> ignored, result unchanged; load_key+load_data together -> key register shifts only.
REQ-035 Reset and ena: rst_n pulsed at RUN cycle 4 -> busy=0, done=0, uo_out=0 immediately; ena low 3 cycles mid-RUN -> done delayed by exactly 3 cycles, ciphertext unchanged.
REQ-036 Readout wrap: 17 rd_next strobes -> uo_out=0xc4 (byte 1); rd_next before done -> uo_out unchanged.

Source files
------------

// File: rtl/tt_um_aes_serial.sv
`default_nettype none
// ============================================================================
// tt_um_aes_serial -- byte-serial AES-128 encrypt/decrypt, ROUNDS_PER_CLK rounds
// per clock. Rev 1.0
// ============================================================================
module tt_um_aes_serial #(
  parameter int ROUNDS_PER_CLK = 1,
  parameter int DECRYPT_EN     = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  generate
    if (ROUNDS_PER_CLK != 1 && ROUNDS_PER_CLK != 2 && ROUNDS_PER_CLK != 5) begin : g_bad_rpc
      $error("tt_um_aes_serial: ROUNDS_PER_CLK must be 1, 2 or 5");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_KEXP = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [3:0] c_rpc = 4'(ROUNDS_PER_CLK);

  // ---------------------------------------------------------------- GF(2^8)
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse (and maps 0 to 0)
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    r = a;
    for (int i = 0; i < 6; i++) r = gmul(gmul(r, r), a);
    return gmul(r, r);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    return gf_inv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
  endfunction

  // ---------------------------------------------------------- round pieces
  // Byte i of a block sits at [127-8i -: 8]; byte 4c+r is row r of column c.
  function automatic logic [127:0] sub_bytes(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    for (int i = 0; i < 16; i++)
      o[8*i +: 8] = inv ? inv_sbox(s[8*i +: 8]) : sbox(s[8*i +: 8]);
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = inv ? s[127-8*(4*((c+4-r)%4)+r) -: 8]
                                    : s[127-8*(4*((c+r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_cols(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    logic [31:0]  cf;
    logic [7:0]   acc;
    cf = inv ? 32'h0e0b0d09 : 32'h02030101;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++)
          acc = acc ^ gmul(cf[31-8*((j+4-r)%4) -: 8], s[127-8*(4*c+j) -: 8]);
        o[127-8*(4*c+r) -: 8] = acc;
      end
    return o;
  endfunction

  function automatic logic [127:0] enc_round(input logic [127:0] s, input logic [127:0] rk,
                                             input logic last);
    logic [127:0] t;
    t = shift_rows(sub_bytes(s, 1'b0), 1'b0);
    if (!last) t = mix_cols(t, 1'b0);
    return t ^ rk;
  endfunction

  function automatic logic [127:0] dec_round(input logic [127:0] s, input logic [127:0] rk,
                                             input logic last);
    logic [127:0] t;
    t = sub_bytes(shift_rows(s, 1'b1), 1'b1) ^ rk;
    if (!last) t = mix_cols(t, 1'b1);
    return t;
  endfunction

  // ----------------------------------------------------------- key schedule
  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] sub_rot(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    {w0, w1, w2, w3} = k;
    w0 = w0 ^ sub_rot(w3) ^ {rc, 24'h0};
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Undo one forward step: rk(i) with rcon(i) gives rk(i-1)
  function automatic logic [127:0] key_inv(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    {w0, w1, w2, w3} = k;
    w3 = w3 ^ w2;
    w2 = w2 ^ w1;
    w1 = w1 ^ w0;
    w0 = w0 ^ sub_rot(w3) ^ {rc, 24'h0};
    return {w0, w1, w2, w3};
  endfunction

  // ---------------------------------------------------------------- state
  state_t       r_fsm, w_fsm_nx;
  logic [127:0] r_key, r_data, r_state, r_rk, r_result;
  logic [3:0]   r_round;
  logic         r_mode;

  logic         w_mode_in, w_avail, w_start, w_ld_key, w_ld_data, w_rot, w_last, w_dec_run;
  logic [127:0] w_st, w_rk;
  logic [3:0]   w_rnd;
  logic         w_unused;

  assign w_unused  = ^uio_in[7:5];
  assign w_mode_in = uio_in[3] && (DECRYPT_EN != 0);
  assign w_avail   = ena && (r_fsm == S_IDLE || r_fsm == S_DONE);
  assign w_start   = w_avail && uio_in[2];
  assign w_ld_key  = w_avail && !uio_in[2] && uio_in[0];
  assign w_ld_data = w_avail && !uio_in[2] && !uio_in[0] && uio_in[1];
  assign w_rot     = w_avail && (r_fsm == S_DONE) && !uio_in[2] && !uio_in[1] && !uio_in[0]
                     && uio_in[4];
  assign w_last    = (r_round + c_rpc) == 4'd11;
  assign w_dec_run = r_mode && (r_fsm == S_RUN);

  // KEXP also uses the forward branch; its state output is simply not captured
  always_comb begin
    w_st  = r_state;
    w_rk  = r_rk;
    w_rnd = r_round;
    for (int k = 0; k < ROUNDS_PER_CLK; k++) begin
      w_rnd = r_round + 4'(k);
      if (w_dec_run) begin
        w_rk = key_inv(w_rk, rcon(4'd11 - w_rnd));
        w_st = dec_round(w_st, w_rk, w_rnd == 4'd10);
      end else begin
        w_rk = key_fwd(w_rk, rcon(w_rnd));
        w_st = enc_round(w_st, w_rk, w_rnd == 4'd10);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_fsm <= S_IDLE;
    else        r_fsm <= w_fsm_nx;
  end

  always_comb begin
    w_fsm_nx = r_fsm;
    case (r_fsm)
      S_IDLE, S_DONE: begin
        if (w_start)                    w_fsm_nx = w_mode_in ? S_KEXP : S_RUN;
        else if (w_ld_key || w_ld_data) w_fsm_nx = S_IDLE;
      end
      S_KEXP:  if (ena && w_last) w_fsm_nx = S_RUN;
      S_RUN:   if (ena && w_last) w_fsm_nx = S_DONE;
      default: w_fsm_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key    <= '0;
      r_data   <= '0;
      r_state  <= '0;
      r_rk     <= '0;
      r_result <= '0;
      r_round  <= '0;
      r_mode   <= 1'b0;
    end else if (ena) begin
      if (w_ld_key)  r_key    <= {r_key[119:0], ui_in};
      if (w_ld_data) r_data   <= {r_data[119:0], ui_in};
      if (w_rot)     r_result <= {r_result[119:0], r_result[127:120]};
      if (w_start) begin
        r_mode  <= w_mode_in;
        r_round <= 4'd1;
        r_rk    <= r_key;
        r_state <= r_data ^ r_key;
      end
      case (r_fsm)
        S_KEXP: begin
          r_rk    <= w_rk;
          r_round <= w_last ? 4'd1 : r_round + c_rpc;
          if (w_last) r_state <= r_data ^ w_rk;
        end
        S_RUN: begin
          r_rk    <= w_rk;
          r_state <= w_st;
          r_round <= r_round + c_rpc;
          if (w_last) r_result <= w_st;
        end
        default: ;
      endcase
    end
  end

  assign uo_out  = r_result[127:120];
  assign uio_out = {r_mode, r_fsm == S_DONE, (r_fsm == S_KEXP) || (r_fsm == S_RUN), 5'b0_0000};
  assign uio_oe  = 8'b1110_0000;

endmodule
`default_nettype wire

// File: tb/tb_tt_um_aes_serial.sv
`default_nettype none
// ============================================================================
// tb_tt_um_aes_serial -- bench for tt_um_aes_serial at ROUNDS_PER_CLK 1, 2, 5
// Rev 1.0
// ============================================================================
module tb_tt_um_aes_serial;

  localparam logic [127:0] c_key = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] c_pt  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] c_ct  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] c_ct0 = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic       clk = 1'b0;
  logic       rst_n, ena, ena_sw;
  logic [7:0] ui_in, uio_in;
  logic [7:0] uo1, uio1, oe1, uo2, uio2, oe2, uo5, uio5, oe5;
  int         n_checks = 0;
  int         n_errors = 0;

  always #5 clk = ~clk;

  tt_um_aes_serial #(.ROUNDS_PER_CLK(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo1), .uio_out(uio1), .uio_oe(oe1));
  tt_um_aes_serial #(.ROUNDS_PER_CLK(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .ena(ena_sw), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo2), .uio_out(uio2), .uio_oe(oe2));
  tt_um_aes_serial #(.ROUNDS_PER_CLK(5)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .ena(ena_sw), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo5), .uio_out(uio5), .uio_oe(oe5));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [7:0] strobe, input logic [127:0] v);
    for (int i = 0; i < 16; i++) begin
      uio_in = strobe;
      ui_in  = v[127-8*i -: 8];
      tick();
    end
    uio_in = 8'h00;
    ui_in  = 8'h00;
  endtask

  task automatic start_op(input logic m);
    uio_in = {4'b0000, m, 3'b100};
    tick();
    uio_in = 8'h00;
  endtask

  task automatic wait_done(input int pre, output int lat);
    lat = 0;
    for (int c = pre + 1; c <= 60; c++) begin
      tick();
      if (uio1[6]) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic wait_sweep(output int l1, output int l2, output int l5);
    l1 = 0;
    l2 = 0;
    l5 = 0;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (l1 == 0 && uio1[6]) l1 = c;
      if (l2 == 0 && uio2[6]) l2 = c;
      if (l5 == 0 && uio5[6]) l5 = c;
    end
  endtask

  task automatic read_all(output logic [127:0] g1, output logic [127:0] g2,
                          output logic [127:0] g5);
    g1 = '0;
    g2 = '0;
    g5 = '0;
    uio_in = 8'h10;
    for (int i = 0; i < 16; i++) begin
      g1 = {g1[119:0], uo1};
      g2 = {g2[119:0], uo2};
      g5 = {g5[119:0], uo5};
      tick();
    end
    uio_in = 8'h00;
  endtask

  initial begin
    int           l1, l2, l5;
    logic [127:0] g1, g2, g5;

    rst_n  = 1'b0;
    ena    = 1'b1;
    ena_sw = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    tick();
    tick();
    chk("rst_uo",  128'({uo1, uo2, uo5}),    128'h0);
    chk("rst_uio", 128'({uio1, uio2, uio5}), 128'h0);
    chk("rst_oe",  128'({oe1, oe2, oe5}),    128'he0e0e0);
    rst_n = 1'b1;
    tick();
    chk("idle_uio", 128'({uio1, uio2, uio5}), 128'h0);
    chk("idle_uo",  128'({uo1, uo2, uo5}),    128'h0);

    // encrypt across all three round widths
    load(8'h01, c_key);
    load(8'h02, c_pt);
    start_op(1'b0);
    chk("enc_busy", 128'({uio1, uio2, uio5}), 128'h202020);
    wait_sweep(l1, l2, l5);
    chk("enc_lat_r1", 128'(l1), 128'd10);
    chk("enc_lat_r2", 128'(l2), 128'd5);
    chk("enc_lat_r5", 128'(l5), 128'd2);
    read_all(g1, g2, g5);
    chk("enc_ct_r1", g1, c_ct);
    chk("enc_ct_r2", g2, c_ct);
    chk("enc_ct_r5", g5, c_ct);

    // decrypt back
    load(8'h02, c_ct);
    start_op(1'b1);
    chk("dec_busy_mode", 128'({uio1, uio2, uio5}), 128'ha0a0a0);
    wait_sweep(l1, l2, l5);
    chk("dec_lat_r1", 128'(l1), 128'd20);
    chk("dec_lat_r2", 128'(l2), 128'd10);
    chk("dec_lat_r5", 128'(l5), 128'd4);
    read_all(g1, g2, g5);
    chk("dec_pt_r1", g1, c_pt);
    chk("dec_pt_r2", g2, c_pt);
    chk("dec_pt_r5", g5, c_pt);
    ena_sw = 1'b0;

    // strobes mid-RUN are ignored
    load(8'h02, c_pt);
    start_op(1'b0);
    repeat (3) tick();
    uio_in = 8'h07;
    ui_in  = 8'hff;
    tick();
    tick();
    uio_in = 8'h00;
    ui_in  = 8'h00;
    wait_done(5, l1);
    chk("conflict_lat", 128'(l1), 128'd10);
    read_all(g1, g2, g5);
    chk("conflict_ct", g1, c_ct);
    start_op(1'b0);
    wait_done(0, l1);
    read_all(g1, g2, g5);
    chk("repeat_ct", g1, c_ct);

    // readout before done and wrap
    start_op(1'b0);
    uio_in = 8'h10;
    repeat (3) tick();
    chk("rd_early", 128'(uo1), 128'h69);
    uio_in = 8'h00;
    wait_done(3, l1);
    chk("rd_done_b0", 128'(uo1), 128'h69);
    uio_in = 8'h10;
    repeat (17) tick();
    uio_in = 8'h00;
    chk("rd_wrap17", 128'(uo1), 128'hc4);

    // ena low for three cycles mid-RUN
    start_op(1'b0);
    repeat (3) tick();
    ena = 1'b0;
    repeat (3) tick();
    chk("ena_hold_busy", 128'(uio1), 128'h20);
    ena = 1'b1;
    wait_done(6, l1);
    chk("ena_lat", 128'(l1), 128'd13);
    read_all(g1, g2, g5);
    chk("ena_ct", g1, c_ct);

    // asynchronous reset mid-RUN
    start_op(1'b0);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("arst_uo",  128'(uo1),  128'h0);
    chk("arst_uio", 128'(uio1), 128'h0);
    chk("arst_oe",  128'(oe1),  128'he0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("arst_idle", 128'(uio1), 128'h0);
    start_op(1'b0);
    wait_done(0, l1);
    chk("zero_lat", 128'(l1), 128'd10);
    read_all(g1, g2, g5);
    chk("zero_ct", g1, c_ct0);

    // load_key and load_data together: only the key shifts
    load(8'h02, c_pt);
    load(8'h03, c_key);
    start_op(1'b0);
    wait_done(0, l1);
    read_all(g1, g2, g5);
    chk("both_load_ct", g1, c_ct);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
